// File: rtl/program_counter.sv
// ============================================================================
// Module      : program_counter
// Description : Program counter register for the processor datapath. Each
//               rising edge applies the winning action, in the order
//               reset > load > increment > hold. The output is registered,
//               so no input reaches pc combinationally.
//               Optional feature macro: PC_WRAP_FLAG_EN (adds registered
//               'wrap' output, high for the cycle after an increment that
//               carried out of the top bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_counter #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] STEP        = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             increment,
    input  logic [WIDTH-1:0] data_in,
`ifdef PC_WRAP_FLAG_EN
    output logic             wrap,
`endif
    output logic [WIDTH-1:0] pc
);

    // One extra bit holds the carry out of the addition; it is only
    // observed when the wrap flag is built in.
    logic [WIDTH:0] w_sum;

    // Next sequential address plus its carry, computed unconditionally.
    always_comb begin
        w_sum = {1'b0, pc} + {1'b0, STEP};
    end

`ifdef PC_WRAP_FLAG_EN
    // Prioritised update of pc; wrap records the carry of a winning increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc   <= RESET_VALUE;
            wrap <= 1'b0;
        end else if (load) begin
            pc   <= data_in;
            wrap <= 1'b0;
        end else if (increment) begin
            pc   <= w_sum[WIDTH-1:0];
            wrap <= w_sum[WIDTH];
        end else begin
            wrap <= 1'b0;
        end
    end
`else
    // Prioritised update of pc; the carry bit is intentionally unused here.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_VALUE;
        end else if (load) begin
            pc <= data_in;
        end else if (increment) begin
            pc <= w_sum[WIDTH-1:0];
        end
    end

    // Carry is consumed only by the wrap flag build; tie it off explicitly.
    logic w_unused_carry;
    assign w_unused_carry = w_sum[WIDTH];
`endif

endmodule

`default_nettype wire

// File: tb/tb_program_counter.sv
// ============================================================================
// Module      : tb_program_counter
// Description : Self-checking bench for program_counter. Directed sequences
//               followed by randomized stimulus, all compared against an
//               arithmetic reference model of the priority rules. Checks the
//               wrap output when PC_WRAP_FLAG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_counter;

    localparam int c_width = 16;
    localparam int c_mod   = 65536;
    localparam int c_step  = 1;
    localparam int c_rst   = 0;

    logic                clk;
    logic                reset;
    logic                load;
    logic                increment;
    logic [c_width-1:0]  data_in;
    logic [c_width-1:0]  pc;
`ifdef PC_WRAP_FLAG_EN
    logic                wrap;
`endif

    int tests_run;
    int tests_failed;

    // Reference model state
    int exp_pc;
    int exp_wrap;

    program_counter #(
        .WIDTH       (c_width),
        .RESET_VALUE (16'h0000),
        .STEP        (16'h0001)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .increment (increment),
        .data_in   (data_in),
`ifdef PC_WRAP_FLAG_EN
        .wrap      (wrap),
`endif
        .pc        (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, advance the model at the
    // rising edge, then compare shortly after.
    task automatic do_cycle(input string tag, input logic r, input logic l,
                            input logic inc, input logic [c_width-1:0] d);
        int sum;
        @(negedge clk);
        reset     = r;
        load      = l;
        increment = inc;
        data_in   = d;
        @(posedge clk);
        exp_wrap = 0;
        if (r) begin
            exp_pc = c_rst;
        end else if (l) begin
            exp_pc = int'(d);
        end else if (inc) begin
            sum      = exp_pc + c_step;
            exp_wrap = (sum >= c_mod) ? 1 : 0;
            exp_pc   = sum % c_mod;
        end
        #1;
        check(tag, 32'(pc), 32'(exp_pc));
`ifdef PC_WRAP_FLAG_EN
        check({tag, "_wrap"}, 32'(wrap), 32'(exp_wrap));
`endif
    endtask

    initial begin
        int r_sel;
        logic rr, ll, ii;
        tests_run    = 0;
        tests_failed = 0;
        exp_pc       = 0;
        exp_wrap     = 0;
        reset        = 1'b0;
        load         = 1'b0;
        increment    = 1'b0;
        data_in      = '0;

        // 1. Reset from an arbitrary state, then idle.
        do_cycle("init_reset", 1, 0, 0, 16'h0000);
        do_cycle("arb_load",   0, 1, 0, 16'h3C5A);
        do_cycle("reset",      1, 0, 0, 16'h0000);
        do_cycle("reset_idle", 0, 0, 0, 16'h0000);
        do_cycle("reset_idle", 0, 0, 0, 16'hFFFF);

        // 2. Load / increment sequence.
        do_cycle("load_aaaa",  0, 1, 0, 16'hAAAA);
        do_cycle("hold_aaaa",  0, 0, 0, 16'h0000);
        do_cycle("inc_aaab",   0, 0, 1, 16'h0000);
        do_cycle("hold_aaab",  0, 0, 0, 16'h0000);
        do_cycle("inc_aaac",   0, 0, 1, 16'h0000);
        do_cycle("load_1234",  0, 1, 0, 16'h1234);
        do_cycle("hold_1234",  0, 0, 0, 16'h0000);

        // 3. Priority.
        do_cycle("load_over_inc", 0, 1, 1, 16'h0100);
        do_cycle("reset_over_ld", 1, 1, 0, 16'h5555);
        do_cycle("reset_over_all",1, 1, 1, 16'h7777);

        // 4. Wrap around the top of the address space.
        do_cycle("load_fffe",  0, 1, 0, 16'hFFFE);
        do_cycle("inc_ffff",   0, 0, 1, 16'h0000);
        do_cycle("inc_wrap",   0, 0, 1, 16'h0000);
        do_cycle("after_wrap", 0, 0, 0, 16'h0000);
        do_cycle("load_ffff",  0, 1, 1, 16'hFFFF);
        do_cycle("ld_no_wrap", 0, 0, 0, 16'h0000);

        // 5. Hold with data_in toggling.
        for (int k = 0; k < 10; k++) begin
            do_cycle("hold_data", 0, 0, 0, 16'($urandom));
        end

        // 6. Continuous increment with reset mid-run.
        do_cycle("load_0010", 0, 1, 0, 16'h0010);
        for (int k = 0; k < 5; k++) begin
            do_cycle("cont_inc", 0, 0, 1, 16'($urandom));
        end
        check("cont_inc_end", 32'(pc), 32'h0015);
        do_cycle("cont_inc", 0, 0, 1, 16'h0000);
        do_cycle("mid_reset", 1, 0, 1, 16'h0000);
        do_cycle("post_reset_inc", 0, 0, 1, 16'h0000);

        // Randomized traffic with weighted actions; loads near the top of the
        // range are frequent so increments cross the wrap point often.
        for (int k = 0; k < 400; k++) begin
            r_sel = int'($urandom_range(0, 99));
            rr = (r_sel < 5);
            ll = ($urandom_range(0, 99) < 20);
            ii = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 1) == 1)
                do_cycle("rand", rr, ll, ii, 16'(16'hFFF0 | 16'($urandom_range(0, 15))));
            else
                do_cycle("rand", rr, ll, ii, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
